// File: rtl/sha256d_pkg.sv
// Shared definitions for the double-SHA-256 nonce scheduler and its helpers.
package sha256d_pkg;

  localparam int unsigned HDR_WORDS  = 19;
  localparam int unsigned NONCE_ADDR = 19;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned ADDR_W     = 5;
  localparam int unsigned HASH_W     = 256;
  localparam int unsigned ZB_W       = 9;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    CHECK
  } state_e;

  // Per-run parameters latched on the start pulse.
  typedef struct packed {
    logic [WORD_W-1:0] nonce_end;
    logic [ZB_W-1:0]   zero_bits;
  } run_cfg_t;

  function automatic logic [WORD_W-1:0] bswap32(input logic [WORD_W-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/hash_zero_check.sv
// Byte-reverses a SHA-256 digest into display order and tests its leading zero bits.
module hash_zero_check
  import sha256d_pkg::*;
(
  input  logic [HASH_W-1:0] hash,
  input  logic [ZB_W-1:0]   zero_bits,
  output logic              meets
);

  logic [HASH_W-1:0] rev;
  logic [HASH_W-1:0] mask;
  logic [ZB_W-1:0]   zb_sat;

  always_comb begin
    rev = '0;
    for (int i = 0; i < HASH_W / 8; i++) begin
      rev[HASH_W-1-8*i -: 8] = hash[8*i +: 8];
    end
  end

  // A shift by the full width yields zero, so 256 selects every bit.
  assign zb_sat = (zero_bits > ZB_W'(HASH_W)) ? ZB_W'(HASH_W) : zero_bits;
  assign mask   = ~({HASH_W{1'b1}} >> zb_sat);
  assign meets  = ((rev & mask) == '0);

endmodule

// File: rtl/sha256d_nonce_sched.sv
// Nonce sweep controller: holds the header prefix, serves the core's word bus,
// launches one double hash per nonce and checks each digest against the difficulty.
module sha256d_nonce_sched
  import sha256d_pkg::*;
#(
  parameter int unsigned NONCE_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [ADDR_W-1:0]   cfg_addr,
  input  logic [WORD_W-1:0]   cfg_wdata,
  input  logic                run,
  input  logic                abort,
  input  logic [NONCE_W-1:0]  nonce_start,
  input  logic [NONCE_W-1:0]  nonce_end,
  input  logic [ZB_W-1:0]     zero_bits,
  output logic                core_start,
  input  logic                core_rq,
  input  logic [ADDR_W-1:0]   core_addr,
  output logic [WORD_W-1:0]   core_data,
  output logic                core_rdy,
  input  logic [HASH_W-1:0]   core_hash,
  input  logic                core_done,
  output logic                busy,
  output logic                found,
  output logic [NONCE_W-1:0]  found_nonce,
  output logic                exhausted,
  output logic [NONCE_W-1:0]  cur_nonce,
  output logic [WORD_W-1:0]   hash_count
);

  logic [WORD_W-1:0]  hdr [HDR_WORDS];
  logic [WORD_W-1:0]  rsp_data_c;

  state_e             state, state_d;
  run_cfg_t           cfg_q, cfg_d;
  logic [HASH_W-1:0]  hash_q, hash_d;
  logic               pend_q, pend_d;
  logic [NONCE_W-1:0] cur_d, found_nonce_d;
  logic [WORD_W-1:0]  count_d;
  logic               found_d, exhausted_d, start_d;
  logic               meets;

  // Header store: no reset, so contents survive a mid-run reset.
  always_ff @(posedge clk) begin
    if (cfg_we && !busy && (cfg_addr < ADDR_W'(HDR_WORDS))) begin
      hdr[cfg_addr] <= cfg_wdata;
    end
  end

  // Word 19 carries the nonce little-endian, as it sits in the serialized header.
  always_comb begin
    rsp_data_c = '0;
    if (core_addr < ADDR_W'(HDR_WORDS)) begin
      rsp_data_c = hdr[core_addr];
    end else if (core_addr == ADDR_W'(NONCE_ADDR)) begin
      rsp_data_c = bswap32(cur_nonce);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_rdy  <= 1'b0;
      core_data <= '0;
    end else begin
      core_rdy <= core_rq;
      if (core_rq) begin
        core_data <= rsp_data_c;
      end
    end
  end

  hash_zero_check u_zero_check (
    .hash      (hash_q),
    .zero_bits (cfg_q.zero_bits),
    .meets     (meets)
  );

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cfg_q       <= '0;
      hash_q      <= '0;
      pend_q      <= 1'b0;
      cur_nonce   <= '0;
      found_nonce <= '0;
      hash_count  <= '0;
      found       <= 1'b0;
      exhausted   <= 1'b0;
      core_start  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_d;
      cfg_q       <= cfg_d;
      hash_q      <= hash_d;
      pend_q      <= pend_d;
      cur_nonce   <= cur_d;
      found_nonce <= found_nonce_d;
      hash_count  <= count_d;
      found       <= found_d;
      exhausted   <= exhausted_d;
      core_start  <= start_d;
      busy        <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d       = state;
    cfg_d         = cfg_q;
    hash_d        = hash_q;
    pend_d        = pend_q;
    cur_d         = cur_nonce;
    found_nonce_d = found_nonce;
    count_d       = hash_count;
    found_d       = found;
    exhausted_d   = exhausted;
    start_d       = 1'b0;

    case (state)
      IDLE: begin
        if (run) begin
          state_d           = LAUNCH;
          cfg_d.nonce_end   = nonce_end;
          cfg_d.zero_bits   = zero_bits;
          cur_d             = nonce_start;
          pend_d            = 1'b0;
          found_nonce_d     = '0;
          count_d           = '0;
          found_d           = 1'b0;
          exhausted_d       = 1'b0;
        end
      end
      LAUNCH: begin
        start_d = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (abort) begin
          pend_d = 1'b1;
        end
        if (core_done) begin
          hash_d  = core_hash;
          state_d = CHECK;
        end
      end
      CHECK: begin
        count_d = hash_count + 32'd1;
        // A hit outranks a pending abort; the range end is tested last.
        if (meets) begin
          found_d       = 1'b1;
          found_nonce_d = cur_nonce;
          state_d       = IDLE;
        end else if (pend_q) begin
          state_d = IDLE;
        end else if (cur_nonce == cfg_q.nonce_end) begin
          exhausted_d = 1'b1;
          state_d     = IDLE;
        end else begin
          cur_d   = cur_nonce + NONCE_W'(1);
          state_d = LAUNCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sha256d_nonce_sched.sv
// Directed bench for sha256d_nonce_sched with a bus-driven mock hashing core.
module tb_sha256d_nonce_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cfg_we;
  logic [4:0]   cfg_addr;
  logic [31:0]  cfg_wdata;
  logic         run, abort;
  logic [31:0]  nonce_start, nonce_end;
  logic [8:0]   zero_bits;
  logic         core_start;
  logic         core_rq;
  logic [4:0]   core_addr;
  logic [31:0]  core_data;
  logic         core_rdy;
  logic [255:0] core_hash;
  logic         core_done;
  logic         busy, found, exhausted;
  logic [31:0]  found_nonce, cur_nonce, hash_count;

  int n_cmp = 0;
  int n_err = 0;

  // Genesis block digest in internal (little-endian) byte order.
  localparam logic [255:0] GEN_HASH =
    256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;

  logic [31:0]  hdr_m [19];
  logic [31:0]  hit_w19;
  logic [255:0] hit_hash;
  logic [31:0]  w19_log [$];

  sha256d_nonce_sched dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .run(run), .abort(abort), .nonce_start(nonce_start), .nonce_end(nonce_end),
    .zero_bits(zero_bits), .core_start(core_start), .core_rq(core_rq), .core_addr(core_addr),
    .core_data(core_data), .core_rdy(core_rdy), .core_hash(core_hash), .core_done(core_done),
    .busy(busy), .found(found), .found_nonce(found_nonce), .exhausted(exhausted),
    .cur_nonce(cur_nonce), .hash_count(hash_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Mock core: fetch words 0..19 plus one out-of-range word, then report a digest.
  int          m_st;
  int          m_word;
  int          m_lat;
  logic        start_prev;
  logic [31:0] w19_q;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st <= 0; m_word <= 0; m_lat <= 0; start_prev <= 1'b0; w19_q <= '0;
      core_rq <= 1'b0; core_addr <= '0; core_done <= 1'b0; core_hash <= '0;
    end else begin
      start_prev <= core_start;
      if (core_start) check("start_width", {255'd0, start_prev}, 256'd0);
      core_done <= 1'b0;
      case (m_st)
        0: if (core_start) begin
          m_word <= 0; core_rq <= 1'b1; core_addr <= 5'd0; m_st <= 1;
        end
        1: begin
          check("rdy_low", {255'd0, core_rdy}, 256'd0);
          core_rq <= 1'b0; m_st <= 2;
        end
        2: begin
          check("rdy_high", {255'd0, core_rdy}, 256'd1);
          if (m_word < 19) check($sformatf("hdr_w%0d", m_word), {224'd0, core_data}, {224'd0, hdr_m[m_word]});
          else if (m_word == 19) begin w19_log.push_back(core_data); w19_q <= core_data; end
          else check("bus_hi_zero", {224'd0, core_data}, 256'd0);
          if (m_word == 20) begin
            m_st <= 3; m_lat <= 3;
          end else begin
            m_word <= m_word + 1; core_rq <= 1'b1;
            core_addr <= (m_word == 19) ? 5'd27 : 5'(m_word + 1); m_st <= 1;
          end
        end
        3: if (m_lat == 0) begin
          core_done <= 1'b1;
          core_hash <= (w19_q == hit_w19) ? hit_hash : {w19_q, 216'd0, 8'h80};
          m_st <= 0;
        end else m_lat <= m_lat - 1;
        default: m_st <= 0;
      endcase
    end
  end

  task automatic start_run(input logic [31:0] s, input logic [31:0] e, input logic [8:0] zb);
    nonce_start = s; nonce_end = e; zero_bits = zb;
    w19_log.delete();
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000 && busy; i++) @(negedge clk);
    check("idle", {255'd0, busy}, 256'd0);
  endtask

  task automatic check_result(input string tag, input logic f, input logic x,
                              input logic [31:0] fn, input logic [31:0] cnt, input logic [31:0] cur);
    check({tag, "_found"}, {255'd0, found}, {255'd0, f});
    check({tag, "_exh"}, {255'd0, exhausted}, {255'd0, x});
    check({tag, "_fnonce"}, {224'd0, found_nonce}, {224'd0, fn});
    check({tag, "_count"}, {224'd0, hash_count}, {224'd0, cnt});
    check({tag, "_cur"}, {224'd0, cur_nonce}, {224'd0, cur});
  endtask

  initial begin
    logic [31:0] exp_w [4];
    int starts;

    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; run = 1'b0; abort = 1'b0;
    nonce_start = '0; nonce_end = '0; zero_bits = '0;
    hit_w19 = 32'h1DAC2B7C; hit_hash = GEN_HASH;
    hdr_m = '{32'h01000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
              32'h3ba3edfd, 32'h7a7b12b2, 32'h7ac72c3e, 32'h67768f61, 32'h7fc81bc3,
              32'h888a5132, 32'h3a9fb8aa, 32'h4b1e5e4a, 32'h29ab5f49, 32'hffff001d};

    #13;
    check("rst_busy", {255'd0, busy}, 256'd0);
    check("rst_found", {255'd0, found}, 256'd0);
    check("rst_exh", {255'd0, exhausted}, 256'd0);
    check("rst_fnonce", {224'd0, found_nonce}, 256'd0);
    check("rst_cur", {224'd0, cur_nonce}, 256'd0);
    check("rst_count", {224'd0, hash_count}, 256'd0);
    check("rst_start", {255'd0, core_start}, 256'd0);
    check("rst_rdy", {255'd0, core_rdy}, 256'd0);
    check("rst_data", {224'd0, core_data}, 256'd0);

    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 19; i++) begin
      cfg_we = 1'b1; cfg_addr = 5'(i); cfg_wdata = hdr_m[i];
      @(negedge clk);
    end
    // Out-of-range header writes must not land anywhere visible.
    cfg_addr = 5'd19; cfg_wdata = 32'h12345678; @(negedge clk);
    cfg_addr = 5'd27; cfg_wdata = 32'hCAFEF00D; @(negedge clk);
    cfg_we = 1'b0;

    // Genesis hit on the fourth nonce.
    start_run(32'h7C2BAC1A, 32'h7C2BAC20, 9'd32);
    wait_idle();
    check_result("gen", 1'b1, 1'b0, 32'h7C2BAC1D, 32'd4, 32'h7C2BAC1D);
    exp_w = '{32'h1AAC2B7C, 32'h1BAC2B7C, 32'h1CAC2B7C, 32'h1DAC2B7C};
    check("gen_nlog", 256'(w19_log.size()), 256'd4);
    for (int i = 0; i < 4 && i < w19_log.size(); i++)
      check($sformatf("gen_w19_%0d", i), {224'd0, w19_log[i]}, {224'd0, exp_w[i]});

    // Exhaust 0..3.
    start_run(32'd0, 32'd3, 9'd32);
    wait_idle();
    check_result("exh", 1'b0, 1'b1, 32'd0, 32'd4, 32'd3);

    // Wrap through 0xFFFFFFFF.
    start_run(32'hFFFFFFFE, 32'h00000001, 9'd256);
    wait_idle();
    check_result("wrap", 1'b0, 1'b1, 32'd0, 32'd4, 32'd1);
    exp_w = '{32'hFEFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h01000000};
    check("wrap_nlog", 256'(w19_log.size()), 256'd4);
    for (int i = 0; i < 4 && i < w19_log.size(); i++)
      check($sformatf("wrap_w19_%0d", i), {224'd0, w19_log[i]}, {224'd0, exp_w[i]});

    // Abort mid-WAIT on the second hash, with a header write attempted while busy.
    start_run(32'd10, 32'd20, 9'd32);
    starts = 0;
    for (int i = 0; i < 500 && starts < 2; i++) begin
      if (core_start) starts++;
      if (starts < 2) @(negedge clk);
    end
    check("abort_sync", 256'(starts), 256'd2);
    repeat (4) @(negedge clk);
    abort = 1'b1; cfg_we = 1'b1; cfg_addr = 5'd0; cfg_wdata = 32'hDEADBEEF;
    @(negedge clk);
    abort = 1'b0; cfg_we = 1'b0;
    wait_idle();
    check_result("abort", 1'b0, 1'b0, 32'd0, 32'd2, 32'd11);

    // Abort in the same cycle as core_done on the first hash.
    start_run(32'd100, 32'd200, 9'd32);
    for (int i = 0; i < 500 && !core_done; i++) @(negedge clk);
    check("done_sync", {255'd0, core_done}, 256'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_idle();
    check_result("abort_done", 1'b0, 1'b0, 32'd0, 32'd1, 32'd100);

    // Zero difficulty, single nonce; a second run while busy is ignored.
    start_run(32'd5, 32'd5, 9'd0);
    nonce_start = 32'd99; nonce_end = 32'd120; zero_bits = 9'd200;
    run = 1'b1; @(negedge clk); run = 1'b0;
    wait_idle();
    check_result("zero", 1'b1, 1'b0, 32'd5, 32'd1, 32'd5);
    check("zero_w19", (w19_log.size() > 0) ? {224'd0, w19_log[0]} : 256'd0, {224'd0, 32'h05000000});

    // Difficulty boundary: genesis digest has exactly 43 leading zero bits.
    hit_w19 = 32'h06000000;
    start_run(32'd6, 32'd6, 9'd43);
    wait_idle();
    check_result("zb43", 1'b1, 1'b0, 32'd6, 32'd1, 32'd6);
    start_run(32'd6, 32'd6, 9'd44);
    wait_idle();
    check_result("zb44", 1'b0, 1'b1, 32'd0, 32'd1, 32'd6);
    hit_hash = '0;
    start_run(32'd6, 32'd6, 9'd511);
    wait_idle();
    check_result("zb511", 1'b1, 1'b0, 32'd6, 32'd1, 32'd6);

    // Reset while the core is fetching, then sweep again on the retained header.
    hit_w19 = 32'h1DAC2B7C; hit_hash = GEN_HASH;
    start_run(32'd0, 32'd3, 9'd32);
    for (int i = 0; i < 200 && !core_rq; i++) @(negedge clk);
    check("rq_sync", {255'd0, core_rq}, 256'd1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", {255'd0, busy}, 256'd0);
    check("arst_cur", {224'd0, cur_nonce}, 256'd0);
    check("arst_rdy", {255'd0, core_rdy}, 256'd0);
    check("arst_data", {224'd0, core_data}, 256'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    start_run(32'h7C2BAC1C, 32'h7C2BAC1E, 9'd32);
    wait_idle();
    check_result("post_rst", 1'b1, 1'b0, 32'h7C2BAC1D, 32'd2, 32'h7C2BAC1D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
